// File: rtl/music_pkg.sv
// Shared definitions for the song playback path: song word field layout,
// the voice allocator FSM state encoding and the rest-note code.
package music_pkg;

  // Note record layout: [15]=0, [14:9] note, [8:3] duration, [2:1] stereo, [0] reserved.
  // Advance record layout: [15]=1, [5:0] wait beats.
  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;
  localparam int STEREO_W   = 2;
  localparam int WAIT_W     = 6;
  localparam int ADV_BIT    = 15;
  localparam int NOTE_LSB   = 9;
  localparam int DUR_LSB    = 3;
  localparam int STEREO_LSB = 1;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT_TIME,
    ACK
  } state_t;

endpackage

// File: rtl/voice_picker.sv
// Combinational voice selection.
// Grants the lowest-index free voice; when every voice is busy it grants the
// voice with the largest age (lowest index on ties) and raises steal.
// Ports:
//   busy_mask  in   per-voice occupancy
//   ages       in   packed ages, voice i at [i*AGE_WIDTH +: AGE_WIDTH]
//   grant      out  one-hot selected voice
//   steal      out  1 when the grant displaces a busy voice
module voice_picker #(
  parameter int NUM_VOICES = 3,
  parameter int AGE_WIDTH  = 8
) (
  input  logic [NUM_VOICES-1:0]           busy_mask,
  input  logic [NUM_VOICES*AGE_WIDTH-1:0] ages,
  output logic [NUM_VOICES-1:0]           grant,
  output logic                            steal
);

  always_comb begin
    logic                 found;
    int                   oldest;
    logic [AGE_WIDTH-1:0] oldest_age;
    grant      = '0;
    steal      = 1'b0;
    found      = 1'b0;
    oldest     = 0;
    oldest_age = ages[AGE_WIDTH-1:0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!found && !busy_mask[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    if (!found) begin
      steal = 1'b1;
      // Strict '>' keeps the lowest index on equal ages.
      for (int i = 1; i < NUM_VOICES; i++) begin
        if (ages[i*AGE_WIDTH +: AGE_WIDTH] > oldest_age) begin
          oldest     = i;
          oldest_age = ages[i*AGE_WIDTH +: AGE_WIDTH];
        end
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (i == oldest) grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Scheduler between the song reader and the note_player voices.
// Decodes song words, loads notes into free voices (or steals the oldest),
// sequences advance records by gating play_enable to the players, and
// returns a one-cycle note_ack per consumed word.
// Optional feature macro VOICE_STEAL_EN: when defined, the oldest voice is
// stolen if all are busy; when undefined, DISPATCH stalls until a voice frees
// and steal_count / age counters are absent.
// Ports:
//   clk, reset (async, active-high)
//   play_enable, beat, note_in, note_valid, voice_done   inputs
//   note_ack, voice_load, voice_note, voice_duration, voice_stereo,
//   advance_time, busy_mask, steal_count                 outputs
module voice_allocator
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int AGE_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  beat,
  input  logic [15:0]           note_in,
  input  logic                  note_valid,
  output logic                  note_ack,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [5:0]            voice_note,
  output logic [5:0]            voice_duration,
  output logic [1:0]            voice_stereo,
  output logic                  advance_time,
  output logic [NUM_VOICES-1:0] busy_mask,
  output logic [7:0]            steal_count
);

  state_t                          state, state_nxt;
  logic [NOTE_W-1:0]               note_q;
  logic [DUR_W-1:0]                dur_q;
  logic [STEREO_W-1:0]             stereo_q;
  logic [WAIT_W-1:0]               wait_q;
  logic [WAIT_W-1:0]               beat_cnt;
  logic [NUM_VOICES-1:0]           busy, grant, load;
  logic                            steal, can_load, accept;
  logic [NUM_VOICES*AGE_WIDTH-1:0] ages_flat;
  logic                            unused_reserved;

  assign unused_reserved = note_in[0];
  assign accept = (state == IDLE) && note_valid && play_enable;

  voice_picker #(
    .NUM_VOICES(NUM_VOICES),
    .AGE_WIDTH (AGE_WIDTH)
  ) u_picker (
    .busy_mask(busy),
    .ages     (ages_flat),
    .grant    (grant),
    .steal    (steal)
  );

`ifdef VOICE_STEAL_EN
  assign can_load = 1'b1;
`else
  // Without stealing, hold in DISPATCH until some voice is free.
  assign can_load = !steal;
`endif

  always_comb begin
    state_nxt    = state;
    load         = '0;
    note_ack     = 1'b0;
    advance_time = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (note_in[ADV_BIT])
            state_nxt = (note_in[WAIT_W-1:0] == '0) ? ACK : WAIT_TIME;
          else if (note_in[NOTE_LSB +: NOTE_W] == REST_NOTE)
            state_nxt = ACK;
          else
            state_nxt = DISPATCH;
        end
      end
      // Completes regardless of play_enable so a latched note is never lost.
      DISPATCH: begin
        if (can_load) begin
          load      = grant;
          state_nxt = ACK;
        end
      end
      WAIT_TIME: begin
        if (play_enable) begin
          advance_time = 1'b1;
          if (beat && (beat_cnt + WAIT_W'(1) == wait_q)) state_nxt = ACK;
        end
      end
      // The ack is always a single pulse; freezing here would repeat it.
      ACK: begin
        note_ack  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      note_q   <= '0;
      dur_q    <= '0;
      stereo_q <= '0;
      wait_q   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        note_q   <= note_in[NOTE_LSB +: NOTE_W];
        dur_q    <= note_in[DUR_LSB +: DUR_W];
        stereo_q <= note_in[STEREO_LSB +: STEREO_W];
        wait_q   <= note_in[WAIT_W-1:0];
        beat_cnt <= '0;
      end else if (state == WAIT_TIME && play_enable && beat) begin
        beat_cnt <= beat_cnt + WAIT_W'(1);
      end
    end
  end

  // A load in the same cycle as done keeps the voice busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~voice_done) | load;
  end

  assign voice_load     = load;
  assign busy_mask      = busy;
  assign voice_note     = (|load) ? note_q   : '0;
  assign voice_duration = (|load) ? dur_q    : '0;
  assign voice_stereo   = (|load) ? stereo_q : '0;

`ifdef VOICE_STEAL_EN
  logic [AGE_WIDTH-1:0] age [NUM_VOICES];
  logic [7:0]           steal_cnt;

  function automatic logic [AGE_WIDTH-1:0] age_sat_inc(input logic [AGE_WIDTH-1:0] a);
    return (&a) ? a : a + AGE_WIDTH'(1);
  endfunction

  function automatic logic [7:0] cnt_sat_inc(input logic [7:0] c);
    return (&c) ? c : c + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
      steal_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load[i])
          age[i] <= '0;
        else if (busy[i] && beat && play_enable)
          age[i] <= age_sat_inc(age[i]);
      end
      if ((|load) && steal) steal_cnt <= cnt_sat_inc(steal_cnt);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) ages_flat[i*AGE_WIDTH +: AGE_WIDTH] = age[i];
  end

  assign steal_count = steal_cnt;
`else
  assign ages_flat   = '0;
  assign steal_count = '0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;
  localparam int NV = 3;

  logic          clk = 1'b0;
  logic          reset, play_enable, beat, note_valid;
  logic [15:0]   note_in;
  logic [NV-1:0] voice_done;
  logic          note_ack, advance_time;
  logic [NV-1:0] voice_load, busy_mask;
  logic [5:0]    voice_note, voice_duration;
  logic [1:0]    voice_stereo;
  logic [7:0]    steal_count;

  int tests = 0;
  int fails = 0;

  // Reference model: voice occupancy, ages in beats, steal count.
  bit m_busy[NV];
  int m_age[NV];
  int m_steals;

  voice_allocator #(.NUM_VOICES(NV), .AGE_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
    .note_in(note_in), .note_valid(note_valid), .note_ack(note_ack),
    .voice_done(voice_done), .voice_load(voice_load), .voice_note(voice_note),
    .voice_duration(voice_duration), .voice_stereo(voice_stereo),
    .advance_time(advance_time), .busy_mask(busy_mask), .steal_count(steal_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NV-1:0] model_mask();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_busy[i];
    return r;
  endfunction

  function automatic bit all_busy();
    for (int i = 0; i < NV; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Voice the spec's rules select; -1 means "must stall".
  function automatic int pick();
    int best;
    for (int i = 0; i < NV; i++) if (!m_busy[i]) return i;
`ifdef VOICE_STEAL_EN
    best = 0;
    for (int i = 1; i < NV; i++) if (m_age[i] > m_age[best]) best = i;
    return best;
`else
    return -1;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_busy[i] = 1'b0;
      m_age[i]  = 0;
    end
    m_steals = 0;
  endfunction

  task automatic do_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
    if (play_enable)
      for (int i = 0; i < NV; i++) if (m_busy[i] && m_age[i] < 255) m_age[i]++;
  endtask

  task automatic do_done(input int v);
    voice_done = NV'(1) << v;
    tick();
    voice_done = '0;
    m_busy[v] = 1'b0;
    check("done_busy", busy_mask, model_mask());
  endtask

  // Sends a note record; done_during >= 0 pulses that voice's done in the load cycle.
  task automatic send_note(input logic [15:0] w, input int done_during);
    logic [5:0] n, d;
    logic [1:0] s;
    int v;
    bit stolen;
    n = w[14:9];
    d = w[8:3];
    s = w[2:1];
    stolen = all_busy();
    v = pick();
    note_valid = 1'b1;
    note_in = w;
    tick();
    note_valid = 1'b0;
    note_in = 16'($urandom);
    if (n == 6'd0) begin
      check("rest_ack", note_ack, 1);
      check("rest_noload", voice_load, 0);
      tick();
      check("rest_ack_end", note_ack, 0);
      return;
    end
    if (v < 0) begin
      for (int c = 0; c < 3; c++) begin
        check("stall_noload", voice_load, 0);
        check("stall_noack", note_ack, 0);
        tick();
      end
      voice_done = NV'(1) << (NV - 1);
      tick();
      voice_done = '0;
      m_busy[NV-1] = 1'b0;
      v = NV - 1;
      stolen = 1'b0;
    end
    check("load", voice_load, 32'd1 << v);
    check("bus_note", voice_note, n);
    check("bus_dur", voice_duration, d);
    check("bus_stereo", voice_stereo, s);
    check("load_noack", note_ack, 0);
    if (done_during >= 0) voice_done = NV'(1) << done_during;
    tick();
    voice_done = '0;
    if (done_during >= 0) m_busy[done_during] = 1'b0;
    if (stolen && m_steals < 255) m_steals++;
    m_busy[v] = 1'b1;
    m_age[v] = 0;
    check("ack", note_ack, 1);
    check("ack_noload", voice_load, 0);
    check("busy", busy_mask, model_mask());
    check("steals", steal_count, m_steals);
    tick();
    check("ack_end", note_ack, 0);
  endtask

  // Advance record; pause_at > 0 drops play_enable for 10 beats before that beat.
  task automatic send_adv(input int n, input int pause_at);
    note_valid = 1'b1;
    note_in = {1'b1, 9'($urandom), 6'(n)};
    tick();
    note_valid = 1'b0;
    if (n == 0) begin
      check("adv0_ack", note_ack, 1);
      check("adv0_noadv", advance_time, 0);
      tick();
      check("adv0_ack_end", note_ack, 0);
      return;
    end
    check("adv_start", advance_time, 1);
    check("adv_noack", note_ack, 0);
    for (int k = 1; k <= n; k++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int c = 0; c < idle; c++) begin
        tick();
        check("adv_hold", advance_time, 1);
      end
      if (k == pause_at) begin
        play_enable = 1'b0;
        #1;
        check("pause_adv", advance_time, 0);
        for (int j = 0; j < 10; j++) do_beat();
        check("pause_noack", note_ack, 0);
        check("pause_adv2", advance_time, 0);
        play_enable = 1'b1;
        #1;
        check("resume_adv", advance_time, 1);
      end
      do_beat();
      if (k < n) begin
        check("adv_mid", advance_time, 1);
        check("adv_mid_noack", note_ack, 0);
      end else begin
        check("adv_ack", note_ack, 1);
        check("adv_drop", advance_time, 0);
      end
    end
    tick();
    check("adv_ack_end", note_ack, 0);
  endtask

  initial begin
    reset = 1'b1;
    play_enable = 1'b1;
    beat = 1'b0;
    note_valid = 1'b0;
    note_in = '0;
    voice_done = '0;
    model_reset();
    #12;
    check("rst_load", voice_load, 0);
    check("rst_ack", note_ack, 0);
    check("rst_adv", advance_time, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_steal", steal_count, 0);
    check("rst_note", voice_note, 0);
    tick();
    reset = 1'b0;
    tick();

    // First note into voice 0, then fill voices 1 and 2.
    send_note(16'h1A28, -1);
    send_note({1'b0, 6'd20, 6'd7, 2'd1, 1'b0}, -1);
    send_note({1'b0, 6'd33, 6'd63, 2'd3, 1'b1}, -1);
    for (int i = 0; i < 3; i++) do_beat();
    do_done(1);
    send_note({1'b0, 6'd63, 6'd1, 2'd2, 1'b0}, -1);
    check("no_steal_yet", steal_count, 0);

    // Build ages 7,9,9 with all voices busy, then force a steal / stall.
    do_done(0);
    do_done(1);
    do_done(2);
    send_note({1'b0, 6'd1, 6'd2, 2'd0, 1'b0}, -1);
    send_note({1'b0, 6'd2, 6'd3, 2'd1, 1'b0}, -1);
    send_note({1'b0, 6'd3, 6'd4, 2'd2, 1'b0}, -1);
    do_beat();
    do_beat();
    do_done(0);
    send_note({1'b0, 6'd4, 6'd5, 2'd3, 1'b0}, -1);
    for (int i = 0; i < 7; i++) do_beat();
    send_note({1'b0, 6'd5, 6'd6, 2'd0, 1'b1}, -1);

    // Saturate every age, then all voices tie.
    for (int i = 0; i < 8; i++) if (!m_busy[i % NV]) send_note({1'b0, 6'd9, 6'd9, 2'd1, 1'b0}, -1);
    for (int i = 0; i < 260; i++) do_beat();
    send_note({1'b0, 6'd10, 6'd11, 2'd2, 1'b0}, -1);

    // Advance records.
    send_adv(4, 0);
    send_adv(0, 0);
    send_adv(5, 3);

    // Done and load on voice 0 in the same cycle.
    do_done(0);
    send_note({1'b0, 6'd12, 6'd13, 2'd1, 1'b0}, 0);
    check("same_cycle_busy0", busy_mask[0], 1);

    // Randomized mix.
    for (int t = 0; t < 60; t++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3)      send_note({1'b0, 15'($urandom)}, -1);
      else if (op <= 5) do_beat();
      else if (op <= 7) do_done($urandom_range(0, NV - 1));
      else if (op == 8) send_adv($urandom_range(0, 6), $urandom_range(0, 2));
      else begin
        play_enable = 1'b0;
        do_beat();
        play_enable = 1'b1;
      end
    end

    // Reset during a wait aborts it with no ack.
    note_valid = 1'b1;
    note_in = 16'h8005;
    tick();
    note_valid = 1'b0;
    do_beat();
    check("pre_rst_adv", advance_time, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_adv", advance_time, 0);
    check("mid_rst_ack", note_ack, 0);
    check("mid_rst_busy", busy_mask, 0);
    check("mid_rst_load", voice_load, 0);
    check("mid_rst_steal", steal_count, 0);
    model_reset();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_noack", note_ack, 0);
      check("post_rst_noadv", advance_time, 0);
    end
    send_note({1'b0, 6'd21, 6'd22, 2'd3, 1'b0}, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Scheduler between the song_reader and the bank of note_player voices.
- Decodes each 16-bit song word and assigns a note to a free voice. When every voice is busy, it steals the oldest voice.
- Sequences time-advance records, which gate play_enable to the players, and returns a one-cycle note_done acknowledge to the song_reader.
- Replaces the fixed three-slot arrangement with parameterised voice sharing.

Parameters:
- NUM_VOICES, 3: number of note_player instances served.
- AGE_WIDTH, 8: width of each voice's saturating age counter, in beats.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play_enable  in  1  from the mcu; low freezes the block
- beat  in  1  one-cycle beat pulse from beat_generator
- note_in  in  16  song word from song_reader
- note_valid  in  1  one-cycle strobe; note_in is valid in that cycle
- note_ack  out  1  one-cycle pulse; the word has been consumed (drives song_reader note_done)
- voice_done  in  NUM_VOICES  done_with_note from each player
- voice_load  out  NUM_VOICES  one-hot load pulse to the selected player
- voice_note  out  6  shared note bus, valid while voice_load is nonzero
- voice_duration  out  6  shared duration bus, beats
- voice_stereo  out  2  shared stereo-side bus
- advance_time  out  1  play_enable to all players
- busy_mask  out  NUM_VOICES  per-voice occupancy
- steal_count  out  8  saturating count of steals since reset

Behaviour:

Song word format:
- Bit [15]=0 is a note record: [14:9] note, [8:3] duration, [2:1] stereo, [0] reserved.
- Bit [15]=1 is an advance record: [5:0] wait beats.

Reset (asynchronous, all state cleared):
- FSM returns to IDLE.
- voice_load=0, note_ack=0, advance_time=0, busy_mask=0, steal_count=0.
- Bus outputs=0 and all ages=0.

FSM states and transitions:
- IDLE: waits for note_valid with play_enable=1. The word is latched.
  - Note record → DISPATCH.
  - Advance record with wait>0 → WAIT_TIME.
  - Advance record with wait=0 → ACK.
  - Note record with note=0 (rest) → ACK, with no load.
- DISPATCH: takes one cycle.
  - Chooses the lowest-index voice with busy=0.
  - If none is free, chooses the voice with the largest age; ties go to the lowest index. steal_count increments (saturating at 255).
  - Drives voice_load[i]=1 for exactly one cycle with the latched fields on the buses.
  - Sets busy[i]=1 and clears age[i]=0, then → ACK.
- WAIT_TIME: advance_time=1.
  - A beat counter increments on each beat and compares against wait.
  - When the counter reaches wait → ACK; advance_time drops in the same cycle as the ACK entry.
- ACK: note_ack=1 for one cycle, then → IDLE.

Latency:
- note_valid at cycle N gives voice_load at N+1 and note_ack at N+2.
- For an advance record, note_ack comes one cycle after the final counted beat.

Busy and age tracking:
- voice_done[i] clears busy[i].
- If voice_done[i] and voice_load[i] occur in the same cycle, the load wins and busy stays 1.
- age[i] increments on beat while busy[i]=1 and saturates at 2^AGE_WIDTH-1.

play_enable=0:
- The FSM holds its state and advance_time=0.
- Beats are ignored by both the wait counter and the ages.
- A pending DISPATCH still completes so that no load is lost.

Other boundary rules:
- note_valid outside IDLE is ignored; the song_reader never issues before note_ack.
- Reset asserted mid-WAIT_TIME aborts the wait with no ack.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: behaviour as described above; the oldest voice is stolen when all voices are busy.
- Undefined:
  - DISPATCH stalls while busy_mask is all ones, with no load and no ack. This back-pressures the song_reader.
  - It proceeds on the first cycle a voice frees, loading that voice.
  - steal_count is tied to 0 and the age counters are not generated.

Decomposition:
- Shared package music_pkg holds:
  - word field positions and widths (NOTE_W=6, DUR_W=6, STEREO_W=2, ADV_BIT=15);
  - the FSM state enum {IDLE, DISPATCH, WAIT_TIME, ACK};
  - the REST_NOTE=0 constant.
- Sub-module voice_picker, purely combinational:
  - inputs: busy_mask and the packed ages;
  - outputs: one-hot grant and a steal flag.
  - It isolates the priority/oldest selection so it can be tested exhaustively on its own.

Test Plan:
- Reset, then note word 0x1A28 (note 13, dur 5, stereo 0), all voices free → voice_load=001 at N+1, note_ack at N+2, busy_mask=001.
- Three notes loaded, then 3 beats, then voice_done[1] pulse, then a fourth note → voice 1 loaded, steal_count stays 0.
- All voices busy with ages 7,9,9 → voice 1 stolen, steal_count=1. Without VOICE_STEAL_EN: no load until voice_done[2], then voice_load=100.
- Advance word 0x8004 → advance_time high for exactly 4 beats; note_ack one cycle after the 4th beat. Word 0x8000 → ack at N+1 with advance_time never high.
- play_enable dropped mid-WAIT_TIME for 10 beats → advance_time=0 and the counter is frozen; after resume, only the remaining beats are counted.
- voice_done[0] and voice_load[0] in the same cycle → busy[0]=1. Reset asserted mid-wait → all outputs 0 immediately, with no note_ack.
